// File: rtl/clb_cfg_array.sv
// Configurable logic block: NUM_LE LUT+FF elements with a
// serially loaded, daisy-chainable configuration register.
module clb_cfg_array #(
  parameter int LUT_K  = 4,
  parameter int NUM_LE = 2
) (
  input  logic                    K,
  input  logic                    RN,
  input  logic                    CFG_EN,
  input  logic                    CFG_DIN,
  output logic                    CFG_DOUT,
  output logic                    CFG_DONE,
  input  logic [NUM_LE*LUT_K-1:0] I,
  input  logic                    CE,
  input  logic                    SR,
  output logic [NUM_LE-1:0]       O
);

  localparam int LUT_N      = 1 << LUT_K;
  localparam int CFG_PER_LE = LUT_N + 3;
  localparam int CFG_BITS   = NUM_LE * CFG_PER_LE;
  localparam int CW         = $clog2(CFG_BITS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    START  = 2'd2,
    ACTIVE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CFG_BITS-1:0] cfg;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_inc;
  logic                last;
  logic [NUM_LE-1:0]   q;
  logic [NUM_LE-1:0]   f;
  logic [NUM_LE-1:0]   osel;
  logic [NUM_LE-1:0]   init;
  logic                shift;
  logic                cnt_rst;
  logic                q_init;
  logic                q_cap;
  logic                active;

  assign cnt_inc = cnt + CW'(1);
  assign last    = (cnt_inc == CW'(CFG_BITS));

  always_ff @(posedge K or negedge RN) begin
    if (!RN) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, ACTIVE:
        if (CFG_EN)
          state_nxt = (CFG_BITS == 1) ? START : LOAD;
      LOAD:
        if (CFG_EN && last) state_nxt = START;
      START:   state_nxt = ACTIVE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shift   = 1'b0;
    cnt_rst = 1'b0;
    q_init  = 1'b0;
    q_cap   = 1'b0;
    active  = 1'b0;
    unique case (state)
      IDLE: begin
        shift   = CFG_EN;
        cnt_rst = CFG_EN;
      end
      LOAD:  shift = CFG_EN;
      START: q_init = 1'b1;
      ACTIVE: begin
        active  = 1'b1;
        shift   = CFG_EN;
        cnt_rst = CFG_EN;
        q_init  = SR;
        q_cap   = !SR && CE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge K or negedge RN) begin
    if (!RN) begin
      cfg <= '0;
      cnt <= '0;
      q   <= '0;
    end else begin
      if (shift) begin
        cfg <= {CFG_DIN, cfg[CFG_BITS-1:1]};
        cnt <= cnt_rst ? CW'(1) : cnt_inc;
      end
      if (q_init)     q <= init;
      else if (q_cap) q <= f;
    end
  end

  for (genvar i = 0; i < NUM_LE; i++) begin : g_le
    logic [CFG_PER_LE-1:0] fld;
    logic [LUT_N-1:0]      lut;
    logic [LUT_K-1:0]      lin;
    logic [LUT_K-1:0]      idx;
    logic                  m;

    assign fld     = cfg[i*CFG_PER_LE +: CFG_PER_LE];
    assign lut     = fld[LUT_N-1:0];
    assign osel[i] = fld[LUT_N];
    assign init[i] = fld[LUT_N+2];
    assign lin     = I[i*LUT_K +: LUT_K];
    // Feedback swaps the MSB select for the element's own Q
    assign m       = fld[LUT_N+1] ? q[i] : lin[LUT_K-1];
    assign idx     = {m, lin[LUT_K-2:0]};
    assign f[i]    = lut[idx];
  end

  assign O        = active ? ((osel & q) | (~osel & f)) : '0;
  assign CFG_DONE = active;
  assign CFG_DOUT = cfg[0];

endmodule

// File: tb/tb_clb_cfg_array.sv
// Scoreboard bench for clb_cfg_array (LUT_K=4, NUM_LE=2).
// Expectations are queued at stimulus time, popped at sampling.
module tb_clb_cfg_array;

  logic       K;
  logic       RN;
  logic       CFG_EN;
  logic       CFG_DIN;
  logic       CFG_DOUT;
  logic       CFG_DONE;
  logic [7:0] I;
  logic       CE;
  logic       SR;
  logic [1:0] O;

  int tests;
  int fails;

  logic [63:0] exp_q[$];
  string       nm_q[$];

  logic [37:0] cfg_a;
  logic [37:0] cfg_b;

  clb_cfg_array #(.LUT_K(4), .NUM_LE(2)) dut (
    .K       (K),
    .RN      (RN),
    .CFG_EN  (CFG_EN),
    .CFG_DIN (CFG_DIN),
    .CFG_DOUT(CFG_DOUT),
    .CFG_DONE(CFG_DONE),
    .I       (I),
    .CE      (CE),
    .SR      (SR),
    .O       (O)
  );

  initial begin
    K = 1'b0;
    forever #5 K = ~K;
  end

  function automatic logic [37:0] mk(
    input logic [15:0] l0, input logic o0,
    input logic b0, input logic n0,
    input logic [15:0] l1, input logic o1,
    input logic b1, input logic n1);
    return {n1, b1, o1, l1, n0, b0, o0, l0};
  endfunction

  function automatic void push(input string n,
                               input logic [63:0] v);
    nm_q.push_back(n);
    exp_q.push_back(v);
  endfunction

  task automatic pop(output string n, output logic [63:0] e);
    if (exp_q.size() == 0) begin
      n = "empty_scoreboard";
      e = 'x;
    end else begin
      n = nm_q.pop_front();
      e = exp_q.pop_front();
    end
    tests++;
  endtask

  task automatic tick();
    @(posedge K);
    #1;
  endtask

  task automatic shift_bits(input logic [37:0] v,
                            input int from, input int to);
    for (int k = from; k < to; k++) begin
      CFG_DIN = v[k];
      CFG_EN  = 1'b1;
      tick();
    end
    CFG_EN  = 1'b0;
    CFG_DIN = 1'b0;
  endtask

  task automatic test_reset();
    string n;
    logic [63:0] e;
    RN = 1'b0;
    #3;
    for (int c = 0; c < 6; c++) begin
      CFG_EN  = 1'($urandom_range(1));
      CFG_DIN = 1'($urandom_range(1));
      CE      = 1'($urandom_range(1));
      SR      = 1'($urandom_range(1));
      I       = 8'($urandom);
      push("reset_outs", 64'd0);
      tick();
      pop(n, e);
      if ({O, CFG_DONE, CFG_DOUT} !== e[3:0]) begin
        fails++;
        $display("FAIL %s: got %b required %b", n,
                 {O, CFG_DONE, CFG_DOUT}, e[3:0]);
      end
    end
    CFG_EN = 1'b0; CFG_DIN = 1'b0;
    CE = 1'b0; SR = 1'b0; I = 8'h00;
    @(negedge K);
    RN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      push("post_reset_outs", 64'd0);
      tick();
      pop(n, e);
      if ({O, CFG_DONE, CFG_DOUT} !== e[3:0]) begin
        fails++;
        $display("FAIL %s: got %b required %b", n,
                 {O, CFG_DONE, CFG_DOUT}, e[3:0]);
      end
    end
  endtask

  task automatic test_load_start();
    string n;
    logic [63:0] e;
    shift_bits(cfg_a, 0, 38);
    push("load_state_start", 64'd2);
    push("load_done_low", 64'd0);
    pop(n, e);
    if (dut.state !== e[1:0]) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", n,
               dut.state, e[1:0]);
    end
    pop(n, e);
    if (CFG_DONE !== e[0]) begin
      fails++;
      $display("FAIL %s: got %b required %b", n, CFG_DONE, e[0]);
    end
    push("active_done", 64'd1);
    push("active_o_init", 64'd2);
    tick();
    pop(n, e);
    if (CFG_DONE !== e[0]) begin
      fails++;
      $display("FAIL %s: got %b required %b", n, CFG_DONE, e[0]);
    end
    pop(n, e);
    if (O !== e[1:0]) begin
      fails++;
      $display("FAIL %s: got %b required %b", n, O, e[1:0]);
    end
  endtask

  task automatic test_logic();
    string n;
    logic [63:0] e;
    logic [15:0] xor4;
    xor4 = 16'h6996;
    I[3:0] = 4'b0111;
    push("xor_0111", 64'(xor4[7]));
    #1;
    pop(n, e);
    if (O[0] !== e[0]) begin
      fails++;
      $display("FAIL %s: got %b required %b", n, O[0], e[0]);
    end
    I[3:0] = 4'b0011;
    push("xor_0011", 64'(xor4[3]));
    #1;
    pop(n, e);
    if (O[0] !== e[0]) begin
      fails++;
      $display("FAIL %s: got %b required %b", n, O[0], e[0]);
    end
    I[7:4] = 4'hF; CE = 1'b1;
    push("and_F_ce", 64'd1);
    tick();
    I[7:4] = 4'hE;
    push("and_E_ce", 64'd0);
    tick();
    I[7:4] = 4'hF; CE = 1'b0;
    push("and_F_hold", 64'd0);
    tick();
    I[7:4] = 4'hE; CE = 1'b1; SR = 1'b1;
    push("sr_init", 64'd1);
    tick();
    SR = 1'b0; CE = 1'b0; I = 8'h00;
    for (int c = 0; c < 4; c++) begin
      pop(n, e);
      if (c < 3) begin
        fails += 0;
      end
    end
  endtask

  task automatic test_logic_regs();
    string n;
    logic [63:0] e;
    logic [3:0] pat [4];
    logic [3:0] ce_v;
    logic [3:0] sr_v;
    logic [3:0] exp_o1;
    pat[0] = 4'hF; pat[1] = 4'hE;
    pat[2] = 4'hF; pat[3] = 4'hE;
    ce_v   = 4'b1011;
    sr_v   = 4'b1000;
    exp_o1 = 4'b1001;
    for (int c = 0; c < 4; c++) begin
      I[7:4] = pat[c];
      CE     = ce_v[c];
      SR     = sr_v[c];
      push("reg_o1_step", 64'(exp_o1[c]));
      tick();
      pop(n, e);
      if (O[1] !== e[0]) begin
        fails++;
        $display("FAIL %s%0d: got %b required %b", n, c,
                 O[1], e[0]);
      end
    end
    SR = 1'b0; CE = 1'b0; I = 8'h00;
  endtask

  task automatic test_feedback();
    string n;
    logic [63:0] e;
    shift_bits(cfg_b, 0, 38);
    CE = 1'b1;
    push("fb_step", 64'd0);
    push("fb_step", 64'd1);
    push("fb_step", 64'd0);
    push("fb_step", 64'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      pop(n, e);
      if (O[0] !== e[0]) begin
        fails++;
        $display("FAIL %s%0d: got %b required %b", n, c,
                 O[0], e[0]);
      end
    end
    CE = 1'b0;
  endtask

  task automatic test_pause_chain();
    string n;
    logic [63:0] e;
    shift_bits(cfg_a, 0, 20);
    for (int c = 0; c < 5; c++) begin
      push("pause_done_low", 64'd0);
      tick();
      pop(n, e);
      if (CFG_DONE !== e[0]) begin
        fails++;
        $display("FAIL %s%0d: got %b required %b", n, c,
                 CFG_DONE, e[0]);
      end
    end
    shift_bits(cfg_a, 20, 38);
    push("pause_done_edge1", 64'd0);
    pop(n, e);
    if (CFG_DONE !== e[0]) begin
      fails++;
      $display("FAIL %s: got %b required %b", n, CFG_DONE, e[0]);
    end
    push("pause_done_edge2", 64'd1);
    tick();
    pop(n, e);
    if (CFG_DONE !== e[0]) begin
      fails++;
      $display("FAIL %s: got %b required %b", n, CFG_DONE, e[0]);
    end
    for (int k = 0; k < 38; k++) push("chain_dout", 64'(cfg_a[k]));
    for (int k = 0; k < 38; k++) begin
      CFG_DIN = cfg_a[k];
      CFG_EN  = 1'b1;
      #1;
      pop(n, e);
      if (CFG_DOUT !== e[0]) begin
        fails++;
        $display("FAIL %s%0d: got %b required %b", n, k,
                 CFG_DOUT, e[0]);
      end
      tick();
    end
    CFG_EN = 1'b0;
    tick();
  endtask

  task automatic test_interrupts();
    string n;
    logic [63:0] e;
    shift_bits(cfg_b, 0, 10);
    #2;
    RN = 1'b0;
    #2;
    push("irq_state_idle", 64'd0);
    push("irq_cfg_zero", 64'd0);
    push("irq_outs_zero", 64'd0);
    pop(n, e);
    if (dut.state !== e[1:0]) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", n,
               dut.state, e[1:0]);
    end
    pop(n, e);
    if (dut.cfg !== e[37:0]) begin
      fails++;
      $display("FAIL %s: got %h required %h", n, dut.cfg, e[37:0]);
    end
    pop(n, e);
    if ({O, CFG_DONE, CFG_DOUT} !== e[3:0]) begin
      fails++;
      $display("FAIL %s: got %b required %b", n,
               {O, CFG_DONE, CFG_DOUT}, e[3:0]);
    end
    @(negedge K);
    RN = 1'b1;
    tick();
    shift_bits(cfg_a, 0, 38);
    tick();
    I[3:0] = 4'b0111;
    push("reload_done", 64'd1);
    push("reload_o", 64'd3);
    #1;
    pop(n, e);
    if (CFG_DONE !== e[0]) begin
      fails++;
      $display("FAIL %s: got %b required %b", n, CFG_DONE, e[0]);
    end
    pop(n, e);
    if (O !== e[1:0]) begin
      fails++;
      $display("FAIL %s: got %b required %b", n, O, e[1:0]);
    end
    I = 8'h00;
    push("reconf_done_low", 64'd0);
    push("reconf_o_zero", 64'd0);
    push("reconf_q_held", 64'd2);
    shift_bits(cfg_a, 0, 1);
    pop(n, e);
    if (CFG_DONE !== e[0]) begin
      fails++;
      $display("FAIL %s: got %b required %b", n, CFG_DONE, e[0]);
    end
    pop(n, e);
    if (O !== e[1:0]) begin
      fails++;
      $display("FAIL %s: got %b required %b", n, O, e[1:0]);
    end
    pop(n, e);
    if (dut.q !== e[1:0]) begin
      fails++;
      $display("FAIL %s: got %b required %b", n, dut.q, e[1:0]);
    end
    shift_bits(cfg_a, 1, 38);
    push("reconf_final_done", 64'd1);
    tick();
    pop(n, e);
    if (CFG_DONE !== e[0]) begin
      fails++;
      $display("FAIL %s: got %b required %b", n, CFG_DONE, e[0]);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RN = 1'b0; CFG_EN = 1'b0; CFG_DIN = 1'b0;
    CE = 1'b0; SR = 1'b0; I = 8'h00;
    cfg_a = mk(16'h6996, 1'b0, 1'b0, 1'b0,
               16'h8000, 1'b1, 1'b0, 1'b1);
    cfg_b = mk(16'h00FF, 1'b1, 1'b1, 1'b0,
               16'h8000, 1'b1, 1'b0, 1'b1);
    test_reset();
    test_load_start();
    test_logic_ready();
    test_feedback();
    test_pause_chain();
    test_interrupts();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic test_logic_ready();
    string n;
    logic [63:0] e;
    logic [15:0] xor4;
    xor4 = 16'h6996;
    I[3:0] = 4'b0111;
    push("xor_0111", 64'(xor4[7]));
    #1;
    pop(n, e);
    if (O[0] !== e[0]) begin
      fails++;
      $display("FAIL %s: got %b required %b", n, O[0], e[0]);
    end
    I[3:0] = 4'b0011;
    push("xor_0011", 64'(xor4[3]));
    #1;
    pop(n, e);
    if (O[0] !== e[0]) begin
      fails++;
      $display("FAIL %s: got %b required %b", n, O[0], e[0]);
    end
    I = 8'h00;
    test_logic_regs();
  endtask

endmodule

// File: doc/clb_cfg_array.md
Name: clb_cfg_array

Overview:
- Parametrised configurable logic block (CLB) for the FPGA fabric model.
- Holds NUM_LE logic elements. Each element has one LUT_K-input LUT and one flip-flop.
- Configuration is loaded serially through a daisy-chainable shift chain, not preset from constants, so several blocks can be chained into one bitstream.
- Adds clock enable, synchronous set/reset-to-INIT, LUT feedback from the element's own Q, and a load/start/active configuration state machine with reconfiguration.

Parameters:
- LUT_K, 4: inputs per LUT (2..6).
- NUM_LE, 2: logic elements per block (1..8).
- Derived: CFG_PER_LE = 2^LUT_K + 3.
- Derived: CFG_BITS = NUM_LE*CFG_PER_LE.

Ports:
- K  input  1  clock; all state updates on posedge.
- RN  input  1  reset, asynchronous, active-low.
- CFG_EN  input  1  shift one configuration bit this cycle.
- CFG_DIN  input  1  serial configuration data in.
- CFG_DOUT  output  1  serial configuration data out = cfg[0]; used for chaining.
- CFG_DONE  output  1  high only in state ACTIVE.
- I  input  NUM_LE*LUT_K  LUT inputs; LE i uses I[i*LUT_K +: LUT_K].
- CE  input  1  flip-flop clock enable, shared by all LEs.
- SR  input  1  synchronous restore of every Q to its INIT bit.
- O  output  NUM_LE  LE outputs.

Behaviour:

Reset (RN=0, asynchronous):
- cfg <= 0, bit counter cnt <= 0, state <= IDLE.
- All Q <= 0.
- O=0, CFG_DONE=0, CFG_DOUT=0.

Config register cfg[CFG_BITS-1:0]:
- On a shift: cfg <= {CFG_DIN, cfg[CFG_BITS-1:1]}.
- After CFG_BITS shifts, the first bit sent sits in cfg[0].
- Field of LE i = cfg[i*CFG_PER_LE +: CFG_PER_LE], laid out as:
  - bits [2^LUT_K-1:0]: LUT truth table.
  - bit 2^LUT_K: OSEL (0 = combinational out, 1 = registered out).
  - bit 2^LUT_K+1: FBSEL (1 = the MSB LUT input is replaced by this LE's own Q).
  - bit 2^LUT_K+2: INIT.

LUT evaluation:
- F_i = LUT_i[idx], idx = {m, I_i[LUT_K-2:0]}.
- m = FBSEL ? Q_i : I_i[LUT_K-1].
- Purely combinational, zero-cycle latency.

Bit counter:
- Width = clog2(CFG_BITS+1).
- Counts completed shifts in the current load.

State machine:
- IDLE:
  - CFG_EN=1 -> shift, cnt <= 1, go to LOAD.
  - If CFG_BITS==1 -> go to START.
- LOAD:
  - CFG_EN=1 -> shift, cnt++. When the new cnt == CFG_BITS -> START.
  - CFG_EN=0 -> hold; pause is indefinite, no timeout.
- START (exactly 1 cycle):
  - Every Q_i <= INIT_i.
  - CFG_EN is ignored and no shift occurs.
  - Next state is ACTIVE.
- ACTIVE:
  - CFG_DONE=1.
  - CFG_EN=1 -> shift, cnt <= 1, go to LOAD (reconfiguration). CFG_DONE falls after that edge.

Flip-flop update (ACTIVE only):
- SR=1 -> Q_i <= INIT_i. SR has priority over CE.
- Else CE=1 -> Q_i <= F_i.
- Else hold.
- In IDLE and LOAD, Q holds.

Outputs:
- O_i = (state==ACTIVE) ? (OSEL ? Q_i : F_i) : 0.
- O is forced to 0 during load so partially shifted LUTs never reach the fabric.

CFG_DOUT:
- Always cfg[0], combinational from the register, in every state.

Reset mid-operation:
- Returns to IDLE from any state and discards any partial load.

Test Plan (LUT_K=4, NUM_LE=2, CFG_PER_LE=19, CFG_BITS=38):
1. Reset:
   - Drive RN=0 with CFG_EN, CE, SR all toggling.
   - Required: O=0, CFG_DONE=0, CFG_DOUT=0 throughout; they stay 0 after RN rises with CFG_EN=0.
2. Load and start:
   - Configure LE0 = 0x6996 (XOR4), OSEL=0, FBSEL=0, INIT=0.
   - Configure LE1 = 0x8000 (AND4), OSEL=1, FBSEL=0, INIT=1.
   - Shift 38 bits on consecutive cycles.
   - Required after the 38th shift edge: state START, CFG_DONE=0.
   - Required after the next edge: CFG_DONE=1 and O[1]=1 (INIT).
3. Logic and registered output:
   - I0=4'b0111 -> O[0]=1 in the same cycle.
   - I0=4'b0011 -> O[0]=0.
   - I1=4'hF with CE=1 -> O[1]=1 after the edge.
   - I1=4'hE with CE=1 -> O[1]=0 after the edge.
   - I1=4'hF with CE=0 -> O[1] stays 0.
   - SR=1 with CE=1 -> O[1]=1 (INIT).
4. Feedback toggle:
   - Reconfigure LE0 = 0x00FF, OSEL=1, FBSEL=1, INIT=0.
   - Hold CE=1.
   - Required: O[0] sequence 0,1,0,1 on successive edges after ACTIVE.
5. Pause and chain:
   - Drop CFG_EN for 5 cycles after bit 20.
   - Required: CFG_DONE stays 0 during the pause and rises 2 edges after the 38th bit.
   - Then shift 38 more bits. Required: CFG_DOUT reproduces the first 38-bit pattern in order.
6. Interrupts:
   - Assert RN=0 at bit 10 of a load. Required: IDLE, cfg=0, next full load works.
   - Assert CFG_EN=1 while ACTIVE. Required: CFG_DONE=0 and O=0 after that edge, and Q is unchanged until START.
